// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC sequencer for the MIPS datapath.
// Takes the resolved ID-stage branch decision and redirects the fetch PC.
// After a redirect it holds the IF/ID flush for FLUSH_CYCLES unstalled cycles.
// It also keeps a saturating debug count of taken redirects.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter int          FLUSH_CYCLES = 1      // legal range 1..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] branch_imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_flush,
  output logic        busy,
  output logic [15:0] redirect_count
);

  // The counter reloads with FLUSH_CYCLES-1. The flush ends on the unstalled
  // edge that finds it at zero, so the window lasts FLUSH_CYCLES cycles.
  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        flush_reg, flush_next;
  logic [15:0] count_reg, count_next;

  logic [31:0] target;
  logic        redir;

  // Word offset, sign-extended and scaled to bytes. The sum wraps modulo 2^32.
  assign target = id_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // A branch only redirects from RUN and never while the pipe is frozen.
  // While in FLUSH, the instruction in ID is being squashed.
  assign redir = (state_reg == RUN) & branch_valid & branch_taken & ~stall;

  // State register: every piece of sequential state. Reset overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      cnt_reg   <= 2'd0;
      flush_reg <= 1'b0;
      count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      flush_reg <= flush_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: enter FLUSH on a redirect, leave on the last unstalled flush cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (redir) state_next = FLUSH;
      FLUSH:   if (!stall && cnt_reg == 2'd0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Datapath and output next values: PC step, flush window and redirect counter.
  always_comb begin
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    flush_next = flush_reg;
    count_next = count_reg;

    // In FLUSH, redir is always 0, so the same PC rule covers both states.
    if (redir) begin
      pc_next = target;
    end else if (!stall) begin
      pc_next = pc_reg + 32'd4;
    end

    case (state_reg)
      RUN: begin
        if (redir) begin
          flush_next = 1'b1;
          cnt_next   = CNT_LOAD;
        end
      end
      FLUSH: begin
        // A stalled cycle freezes the window, which stretches it 1:1.
        if (!stall) begin
          if (cnt_reg == 2'd0) begin
            flush_next = 1'b0;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end
      end
      default: begin
        flush_next = 1'b0;
        cnt_next   = 2'd0;
      end
    endcase

    if (redir && count_reg != 16'hFFFF) begin
      count_next = count_reg + 16'd1;
    end
  end

  assign pc             = pc_reg;
  assign pc_plus4       = pc_reg + 32'd4;
  assign if_flush       = flush_reg;
  assign busy           = (state_reg == FLUSH);
  assign redirect_count = count_reg;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed tests for branch_pc_unit.
// Three instances (FLUSH_CYCLES = 1, 2, 3) share one stimulus.
// Each test resets all three instances, then checks the instance it targets.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] id_pc_plus4;
  logic [15:0] branch_imm;

  logic [31:0] pc1, pc2, pc3;
  logic [31:0] pc_plus4_1, pc_plus4_2, pc_plus4_3;
  logic        if_flush1, if_flush2, if_flush3;
  logic        busy1, busy2, busy3;
  logic [15:0] count1, count2, count3;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pc_unit #(.RESET_PC(32'd0), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .id_pc_plus4(id_pc_plus4), .branch_imm(branch_imm),
    .pc(pc1), .pc_plus4(pc_plus4_1), .if_flush(if_flush1), .busy(busy1),
    .redirect_count(count1)
  );

  branch_pc_unit #(.RESET_PC(32'd0), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .id_pc_plus4(id_pc_plus4), .branch_imm(branch_imm),
    .pc(pc2), .pc_plus4(pc_plus4_2), .if_flush(if_flush2), .busy(busy2),
    .redirect_count(count2)
  );

  branch_pc_unit #(.RESET_PC(32'd0), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .id_pc_plus4(id_pc_plus4), .branch_imm(branch_imm),
    .pc(pc3), .pc_plus4(pc_plus4_3), .if_flush(if_flush3), .busy(busy3),
    .redirect_count(count3)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge. Outputs are sampled on the falling edge.
  task automatic set_branch(input logic v, input logic t, input logic [31:0] p4, input logic [15:0] imm);
    branch_valid = v;
    branch_taken = t;
    id_pc_plus4  = p4;
    branch_imm   = imm;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b0;
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    stall = 1'b0;
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] reset: pc=%h pc_plus4=%h flush=%b busy=%b count=%h", pc1, pc_plus4_1, if_flush1, busy1, count1);
    n_tests++; if (pc1 !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc1, 32'h0); end
    n_tests++; if (pc_plus4_1 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4_1, 32'h4); end
    n_tests++; if (if_flush1 !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", if_flush1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_tests++; if (count1 !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", count1); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      $display("[TB] seq fetch %0d: pc=%h flush=%b", i, pc1, if_flush1);
      n_tests++; if (pc1 !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, pc1, 32'(4 * i)); end
      n_tests++; if (if_flush1 !== 1'b0) begin n_fail++; $display("FAIL seq_flush%0d: got %b want 0", i, if_flush1); end
    end
  endtask

  task automatic test_backward_branch();
    do_reset();
    repeat (16) @(negedge clk);
    n_tests++; if (pc1 !== 32'h40) begin n_fail++; $display("FAIL bwd_setup_pc: got %h want %h", pc1, 32'h40); end
    set_branch(1'b1, 1'b1, 32'h3C, 16'hFFFE);
    @(negedge clk);
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    $display("[TB] backward branch: pc=%h flush=%b busy=%b count=%h", pc1, if_flush1, busy1, count1);
    n_tests++; if (pc1 !== 32'h34) begin n_fail++; $display("FAIL bwd_pc: got %h want %h", pc1, 32'h34); end
    n_tests++; if (if_flush1 !== 1'b1) begin n_fail++; $display("FAIL bwd_flush: got %b want 1", if_flush1); end
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL bwd_busy: got %b want 1", busy1); end
    n_tests++; if (count1 !== 16'h1) begin n_fail++; $display("FAIL bwd_count: got %h want 1", count1); end
    @(negedge clk);
    $display("[TB] backward after flush: pc=%h flush=%b busy=%b", pc1, if_flush1, busy1);
    n_tests++; if (pc1 !== 32'h38) begin n_fail++; $display("FAIL bwd_pc_after: got %h want %h", pc1, 32'h38); end
    n_tests++; if (if_flush1 !== 1'b0) begin n_fail++; $display("FAIL bwd_flush_end: got %b want 0", if_flush1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL bwd_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_not_taken();
    do_reset();
    repeat (4) @(negedge clk);
    set_branch(1'b1, 1'b0, 32'h100, 16'h0040);
    @(negedge clk);
    $display("[TB] not taken: pc=%h flush=%b count=%h", pc1, if_flush1, count1);
    n_tests++; if (pc1 !== 32'h14) begin n_fail++; $display("FAIL nt_pc: got %h want %h", pc1, 32'h14); end
    n_tests++; if (if_flush1 !== 1'b0) begin n_fail++; $display("FAIL nt_flush: got %b want 0", if_flush1); end
    n_tests++; if (count1 !== 16'h0) begin n_fail++; $display("FAIL nt_count: got %h want 0", count1); end
    // taken without valid must also be ignored
    set_branch(1'b0, 1'b1, 32'h100, 16'h0040);
    @(negedge clk);
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    $display("[TB] taken without valid: pc=%h flush=%b count=%h", pc1, if_flush1, count1);
    n_tests++; if (pc1 !== 32'h18) begin n_fail++; $display("FAIL nv_pc: got %h want %h", pc1, 32'h18); end
    n_tests++; if (count1 !== 16'h0) begin n_fail++; $display("FAIL nv_count: got %h want 0", count1); end
  endtask

  task automatic test_stall_pending();
    do_reset();
    stall = 1'b1;
    set_branch(1'b1, 1'b1, 32'h20, 16'h0004);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      $display("[TB] stalled branch %0d: pc=%h flush=%b count=%h", i, pc2, if_flush2, count2);
      n_tests++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL stall_pc%0d: got %h want 0", i, pc2); end
      n_tests++; if (if_flush2 !== 1'b0) begin n_fail++; $display("FAIL stall_flush%0d: got %b want 0", i, if_flush2); end
      n_tests++; if (count2 !== 16'h0) begin n_fail++; $display("FAIL stall_count%0d: got %h want 0", i, count2); end
    end
    stall = 1'b0;
    @(negedge clk);
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    $display("[TB] stall released: pc=%h flush=%b count=%h", pc2, if_flush2, count2);
    n_tests++; if (pc2 !== 32'h30) begin n_fail++; $display("FAIL stall_redir_pc: got %h want %h", pc2, 32'h30); end
    n_tests++; if (if_flush2 !== 1'b1) begin n_fail++; $display("FAIL stall_redir_flush: got %b want 1", if_flush2); end
    n_tests++; if (count2 !== 16'h1) begin n_fail++; $display("FAIL stall_redir_count: got %h want 1", count2); end
    @(negedge clk);
    $display("[TB] flush cycle 2: pc=%h flush=%b", pc2, if_flush2);
    n_tests++; if (pc2 !== 32'h34) begin n_fail++; $display("FAIL stall_f2_pc: got %h want %h", pc2, 32'h34); end
    n_tests++; if (if_flush2 !== 1'b1) begin n_fail++; $display("FAIL stall_f2_flush: got %b want 1", if_flush2); end
    @(negedge clk);
    $display("[TB] flush done: pc=%h flush=%b busy=%b", pc2, if_flush2, busy2);
    n_tests++; if (pc2 !== 32'h38) begin n_fail++; $display("FAIL stall_f3_pc: got %h want %h", pc2, 32'h38); end
    n_tests++; if (if_flush2 !== 1'b0) begin n_fail++; $display("FAIL stall_f3_flush: got %b want 0", if_flush2); end
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL stall_f3_busy: got %b want 0", busy2); end
  endtask

  task automatic test_flush_branch_stall();
    // Per-edge stimulus and expected instance-3 state after that edge.
    logic        v_tab  [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        s_tab  [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] p_tab  [0:5] = '{32'h100, 32'h200, 32'h0, 32'h0, 32'h300, 32'h300};
    logic [31:0] pc_tab [0:5] = '{32'h100, 32'h104, 32'h104, 32'h108, 32'h10C, 32'h300};
    logic        f_tab  [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] c_tab  [0:5] = '{16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      stall = s_tab[i];
      set_branch(v_tab[i], v_tab[i], p_tab[i], 16'h0000);
      @(negedge clk);
      $display("[TB] flush3 edge %0d: pc=%h flush=%b busy=%b count=%h", i, pc3, if_flush3, busy3, count3);
      n_tests++; if (pc3 !== pc_tab[i]) begin n_fail++; $display("FAIL fl3_pc%0d: got %h want %h", i, pc3, pc_tab[i]); end
      n_tests++; if (if_flush3 !== f_tab[i]) begin n_fail++; $display("FAIL fl3_flush%0d: got %b want %b", i, if_flush3, f_tab[i]); end
      n_tests++; if (count3 !== c_tab[i]) begin n_fail++; $display("FAIL fl3_count%0d: got %h want %h", i, count3, c_tab[i]); end
    end
    stall = 1'b0;
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
  endtask

  task automatic test_wrap_reset();
    do_reset();
    set_branch(1'b1, 1'b1, 32'h0, 16'hFFFF);
    @(negedge clk);
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    $display("[TB] wrap redirect: pc=%h pc_plus4=%h flush=%b", pc1, pc_plus4_1, if_flush1);
    n_tests++; if (pc1 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_target: got %h want %h", pc1, 32'hFFFFFFFC); end
    n_tests++; if (pc_plus4_1 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4_1); end
    @(negedge clk);
    $display("[TB] wrap step: pc=%h flush=%b", pc1, if_flush1);
    n_tests++; if (pc1 !== 32'h0) begin n_fail++; $display("FAIL wrap_step: got %h want 0", pc1); end
    set_branch(1'b1, 1'b1, 32'h0, 16'hFFFF);
    @(negedge clk);
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    $display("[TB] second redirect: pc=%h busy1=%b busy3=%b", pc1, busy1, busy3);
    n_tests++; if (busy3 !== 1'b1) begin n_fail++; $display("FAIL wrap_busy3: got %b want 1", busy3); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset mid-flush: pc=%h flush=%b busy=%b count=%h flush3=%b busy3=%b", pc1, if_flush1, busy1, count1, if_flush3, busy3);
    n_tests++; if (pc1 !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc1); end
    n_tests++; if (if_flush1 !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", if_flush1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy1); end
    n_tests++; if (count1 !== 16'h0) begin n_fail++; $display("FAIL rst_count: got %h want 0", count1); end
    n_tests++; if (if_flush3 !== 1'b0) begin n_fail++; $display("FAIL rst_flush3: got %b want 0", if_flush3); end
    n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rst_busy3: got %b want 0", busy3); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt [0:2] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    do_reset();
    // Preload near the top; 0x10000 real redirects would take too many cycles.
    force dut1.count_reg = 16'hFFFD;
    #1;
    release dut1.count_reg;
    for (int i = 0; i < 3; i++) begin
      set_branch(1'b1, 1'b1, 32'h80, 16'h0000);
      @(negedge clk);
      set_branch(1'b0, 1'b0, 32'd0, 16'd0);
      $display("[TB] saturation redirect %0d: count=%h", i, count1);
      n_tests++; if (count1 !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_count%0d: got %h want %h", i, count1, exp_cnt[i]); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    set_branch(1'b0, 1'b0, 32'd0, 16'd0);
    test_reset();
    test_backward_branch();
    test_not_taken();
    test_stall_pending();
    test_flush_branch_stall();
    test_wrap_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
